// File: rtl/operand_feeder.sv
// Operand-pair FIFO presenting A/B to a strobe/ack multiplier interface.
// Optional SUBNORMAL_FLUSH_EN flushes subnormal operands to signed zero.
module operand_feeder #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              in_a,
  input  logic [31:0]              in_b,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [31:0]              output_a,
  output logic                     output_a_stb,
  input  logic                     output_a_ack,
  output logic [31:0]              output_b,
  output logic                     output_b_stb,
  input  logic                     output_b_ack,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_A_DONE = 2'd2;
  localparam logic [1:0] S_B_DONE = 2'd3;

  logic [31:0]   mem_a [DEPTH];
  logic [31:0]   mem_b [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [1:0]    state;
  logic [1:0]    state_nx;
  logic [AW:0]   count_nx;
  logic          push;
  logic          pop;
  logic          a_xfer;
  logic          b_xfer;

  function automatic logic [31:0] flush(input logic [31:0] v);
`ifdef SUBNORMAL_FLUSH_EN
    if (v[30:23] == 8'd0 && v[22:0] != 23'd0)
      return {v[31], 31'b0};
`endif
    return v;
  endfunction

  assign output_a_stb = (state == S_PEND) || (state == S_B_DONE);
  assign output_b_stb = (state == S_PEND) || (state == S_A_DONE);

  assign a_xfer = output_a_stb & output_a_ack;
  assign b_xfer = output_b_stb & output_b_ack;
  assign push   = in_valid & in_ready;

  always_comb begin
    pop = 1'b0;
    unique case (state)
      S_PEND:   pop = a_xfer & b_xfer;
      S_A_DONE: pop = b_xfer;
      S_B_DONE: pop = a_xfer;
      default:  pop = 1'b0;
    endcase
  end

  assign count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

  always_comb begin
    state_nx = state;
    unique case (state)
      S_EMPTY: if (count != '0) state_nx = S_PEND;
      S_PEND: begin
        if (a_xfer && !b_xfer)
          state_nx = S_A_DONE;
        else if (b_xfer && !a_xfer)
          state_nx = S_B_DONE;
      end
      default: state_nx = state;
    endcase
    // a pair that lands in the same edge as the pop is presented next
    if (pop)
      state_nx = (count_nx != '0) ? S_PEND : S_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_EMPTY;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      in_ready <= (count_nx < FULL);
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  // storage is not reset, so outputs are forced to zero while nothing is held
  assign output_a = (state == S_EMPTY) ? 32'd0 : flush(mem_a[rd_ptr]);
  assign output_b = (state == S_EMPTY) ? 32'd0 : flush(mem_b[rd_ptr]);

endmodule
